// File: rtl/uart_sipo_if.sv
// Serial line, frame-format controls and receive status for the UART deserializer.
interface uart_sipo_if;
  logic       data_tx;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_parll;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_tx, parity_type, stop_bits, data_length,
    input  data_parll, rx_active, rx_done, parity_error, stop_error
  );

  modport slave (
    input  data_tx, parity_type, stop_bits, data_length,
    output data_parll, rx_active, rx_done, parity_error, stop_error
  );
endinterface

// File: rtl/uart_sipo.sv
// UART receive deserializer: start, 7/8 data bits LSB first, optional parity, 1/2 stop bits.
// Define RX_MAJORITY_VOTE_EN for 3-sample majority voting around each bit centre.
module uart_sipo #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic        BaudOut,
  input  logic        rst,
  uart_sipo_if.slave  rx_if
);

  localparam int unsigned HALF   = OVERSAMPLE / 2;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
`ifdef RX_MAJORITY_VOTE_EN
  localparam int unsigned START_TICK = HALF;
`else
  localparam int unsigned START_TICK = HALF - 1;
`endif
  localparam int unsigned LAST_TICK  = OVERSAMPLE - 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic              sync1_q, sync1_d, s_q, s_d, s_prev_q, s_prev_d;
`ifdef RX_MAJORITY_VOTE_EN
  logic              s_prev2_q, s_prev2_d;
`endif
  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              perr_q, perr_d, serr_q, serr_d, stop_cnt_q, stop_cnt_d;
  logic [1:0]        ptype_q, ptype_d;
  logic              stop2_q, stop2_d, len8_q, len8_d;
  logic [7:0]        data_parll_q, data_parll_d;
  logic              rx_active_q, rx_active_d, rx_done_q, rx_done_d;
  logic              parity_error_q, parity_error_d, stop_error_q, stop_error_d;
  logic              bit_s, sample, par_x;

  // Line synchronizer and edge/vote history
  always_comb begin
    sync1_d  = rx_if.data_tx;
    s_d      = sync1_q;
    s_prev_d = s_q;
`ifdef RX_MAJORITY_VOTE_EN
    s_prev2_d = s_prev_q;
    bit_s     = (s_q & s_prev_q) | (s_q & s_prev2_q) | (s_prev_q & s_prev2_q);
`else
    bit_s     = s_q;
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q + TICK_W'(1);
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    perr_d         = perr_q;
    serr_d         = serr_q;
    stop_cnt_d     = stop_cnt_q;
    ptype_d        = ptype_q;
    stop2_d        = stop2_q;
    len8_d         = len8_q;
    data_parll_d   = data_parll_q;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    rx_done_d      = 1'b0;
    par_x          = (^shreg_q) ^ bit_s;
    sample         = (state_q == START) ? (tick_q == TICK_W'(START_TICK))
                                        : (tick_q == TICK_W'(LAST_TICK));
    case (state_q)
      IDLE: begin
        tick_d = tick_q;
        if (s_prev_q && !s_q) begin
          // the edge cycle itself counts as tick 0
          state_d    = START;
          tick_d     = TICK_W'(1);
          ptype_d    = rx_if.parity_type;
          stop2_d    = rx_if.stop_bits;
          len8_d     = rx_if.data_length;
          shreg_d    = 8'h00;
          bit_cnt_d  = 3'd0;
          perr_d     = 1'b0;
          serr_d     = 1'b0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          tick_d  = '0;
          state_d = bit_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          tick_d             = '0;
          shreg_d[bit_cnt_q] = bit_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == (len8_q ? 3'd7 : 3'd6))
            state_d = (ptype_q == 2'b01 || ptype_q == 2'b10) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) begin
          tick_d  = '0;
          perr_d  = (ptype_q == 2'b01) ? ~par_x : par_x;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          tick_d = '0;
          serr_d = serr_q | ~bit_s;
          if (stop_cnt_q == stop2_q) begin
            state_d        = DONE;
            rx_done_d      = 1'b1;
            data_parll_d   = shreg_q;
            parity_error_d = perr_q;
            stop_error_d   = serr_q | ~bit_s;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rx_active_d = (state_d != IDLE);
  end

  always_ff @(posedge BaudOut or negedge rst) begin
    if (!rst) begin
      sync1_q        <= 1'b1;
      s_q            <= 1'b1;
      s_prev_q       <= 1'b1;
`ifdef RX_MAJORITY_VOTE_EN
      s_prev2_q      <= 1'b1;
`endif
      state_q        <= IDLE;
      tick_q         <= '0;
      bit_cnt_q      <= 3'd0;
      shreg_q        <= 8'h00;
      perr_q         <= 1'b0;
      serr_q         <= 1'b0;
      stop_cnt_q     <= 1'b0;
      ptype_q        <= 2'b00;
      stop2_q        <= 1'b0;
      len8_q         <= 1'b0;
      data_parll_q   <= 8'h00;
      rx_active_q    <= 1'b0;
      rx_done_q      <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      s_q            <= s_d;
      s_prev_q       <= s_prev_d;
`ifdef RX_MAJORITY_VOTE_EN
      s_prev2_q      <= s_prev2_d;
`endif
      state_q        <= state_d;
      tick_q         <= tick_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      perr_q         <= perr_d;
      serr_q         <= serr_d;
      stop_cnt_q     <= stop_cnt_d;
      ptype_q        <= ptype_d;
      stop2_q        <= stop2_d;
      len8_q         <= len8_d;
      data_parll_q   <= data_parll_d;
      rx_active_q    <= rx_active_d;
      rx_done_q      <= rx_done_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign rx_if.data_parll   = data_parll_q;
  assign rx_if.rx_active    = rx_active_q;
  assign rx_if.rx_done      = rx_done_q;
  assign rx_if.parity_error = parity_error_q;
  assign rx_if.stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_sipo.sv
// Directed self-checking bench for uart_sipo (honours RX_MAJORITY_VOTE_EN).
module tb_uart_sipo;
  localparam int OS  = 16;
  localparam int LAT = 2;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int MV = 1;
`else
  localparam int MV = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_sipo_if bus ();

  uart_sipo #(.OVERSAMPLE(OS)) dut (.BaudOut(clk), .rst(rst_n), .rx_if(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int done_cnt = 0;
  int done_cyc = 0;
  logic [7:0] done_data = 8'h00;
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_data = bus.data_parll;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Expected cycles from first line low to the rx_done sample, frame of n bits incl. start.
  function automatic int exp_done(input int n);
    return LAT + OS / 2 - 1 + OS * (n - 1) + 1 + MV;
  endfunction

  task automatic build(input logic [7:0] d, input int nd, input int pbit, input int nstop,
                       input logic stop_val, output logic [15:0] bits, output int n);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
    if (pbit >= 0) begin bits[n] = pbit[0]; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = stop_val; n++; end
  endtask

  task automatic drive(input logic [15:0] bits, input int ncyc, input int glitch_c, input int chg_c);
    for (int c = 0; c < ncyc; c++) begin
      bus.data_tx = bits[c / OS] ^ (c == glitch_c);
      if (c == chg_c) bus.data_length = ~bus.data_length;
      @(posedge clk); #1;
    end
    bus.data_tx = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] pt, input logic sb, input logic dl);
    bus.parity_type = pt;
    bus.stop_bits   = sb;
    bus.data_length = dl;
  endtask

  task automatic test_reset;
    bus.data_tx = 1'b1;
    cfg(2'b00, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    n_vec++; if (bus.data_parll !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.data_parll); end
    n_vec++; if (bus.rx_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", bus.rx_active); end
    n_vec++; if (bus.rx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.rx_done); end
    n_vec++; if (bus.parity_error !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", bus.parity_error); end
    n_vec++; if (bus.stop_error !== 1'b0) begin n_err++; $display("FAIL reset_serr: got %b want 0", bus.stop_error); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_8n1;
    logic [15:0] b; int n, base, st;
    cfg(2'b00, 1'b0, 1'b1);
    build(8'hA5, 8, -1, 1, 1'b1, b, n);
    base = done_cnt; st = cyc;
    drive(b, n * OS, -1, -1);
    repeat (4) @(posedge clk); #1;
    n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL 8n1_count: got %0d want 1", done_cnt - base); end
    n_vec++; if (done_cyc - st !== exp_done(n)) begin n_err++; $display("FAIL 8n1_time: got %0d want %0d", done_cyc - st, exp_done(n)); end
    n_vec++; if (bus.data_parll !== 8'hA5) begin n_err++; $display("FAIL 8n1_data: got %h want a5", bus.data_parll); end
    n_vec++; if (bus.parity_error !== 1'b0) begin n_err++; $display("FAIL 8n1_perr: got %b want 0", bus.parity_error); end
    n_vec++; if (bus.stop_error !== 1'b0) begin n_err++; $display("FAIL 8n1_serr: got %b want 0", bus.stop_error); end
    n_vec++; if (bus.rx_active !== 1'b0) begin n_err++; $display("FAIL 8n1_idle: got %b want 0", bus.rx_active); end
  endtask

  task automatic test_parity_odd;
    logic [15:0] b; int n, base;
    cfg(2'b01, 1'b0, 1'b1);
    for (int p = 1; p >= 0; p--) begin
      build(8'h4A, 8, p, 1, 1'b1, b, n);
      base = done_cnt;
      drive(b, n * OS, -1, -1);
      repeat (4) @(posedge clk); #1;
      n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL odd_count p=%0d: got %0d want 1", p, done_cnt - base); end
      n_vec++; if (bus.data_parll !== 8'h4A) begin n_err++; $display("FAIL odd_data p=%0d: got %h want 4a", p, bus.data_parll); end
      n_vec++; if (bus.parity_error !== p[0]) begin n_err++; $display("FAIL odd_perr p=%0d: got %b want %b", p, bus.parity_error, p[0]); end
    end
  endtask

  task automatic test_7e2_len_change;
    logic [15:0] b; int n, base, st;
    cfg(2'b10, 1'b1, 1'b0);
    build(8'h30, 7, 0, 2, 1'b1, b, n);
    base = done_cnt; st = cyc;
    drive(b, n * OS, -1, 40);
    repeat (4) @(posedge clk); #1;
    n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL 7e2_count: got %0d want 1", done_cnt - base); end
    n_vec++; if (done_cyc - st !== exp_done(n)) begin n_err++; $display("FAIL 7e2_time: got %0d want %0d", done_cyc - st, exp_done(n)); end
    n_vec++; if (bus.data_parll !== 8'h30) begin n_err++; $display("FAIL 7e2_data: got %h want 30", bus.data_parll); end
    n_vec++; if (bus.parity_error !== 1'b0) begin n_err++; $display("FAIL 7e2_perr: got %b want 0", bus.parity_error); end
    n_vec++; if (bus.stop_error !== 1'b0) begin n_err++; $display("FAIL 7e2_serr: got %b want 0", bus.stop_error); end
  endtask

  task automatic test_break;
    logic [15:0] b; int n, base, act;
    cfg(2'b00, 1'b0, 1'b1);
    build(8'h55, 8, -1, 1, 1'b0, b, n);
    base = done_cnt; act = 0;
    drive(b, n * OS, -1, -1);
    bus.data_tx = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.rx_active !== 1'b0) act++; end
    n_vec++; if (act !== 0) begin n_err++; $display("FAIL break_active: got %0d active cycles want 0", act); end
    n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL break_count: got %0d want 1", done_cnt - base); end
    n_vec++; if (bus.stop_error !== 1'b1) begin n_err++; $display("FAIL break_serr: got %b want 1", bus.stop_error); end
    n_vec++; if (bus.data_parll !== 8'h55) begin n_err++; $display("FAIL break_data: got %h want 55", bus.data_parll); end
    @(posedge clk); #1;
    bus.data_tx = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_vec++; if (bus.rx_active !== 1'b0) begin n_err++; $display("FAIL break_high: got %b want 0", bus.rx_active); end
    build(8'h5A, 8, -1, 1, 1'b1, b, n);
    base = done_cnt;
    drive(b, n * OS, -1, -1);
    repeat (4) @(posedge clk); #1;
    n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL recover_count: got %0d want 1", done_cnt - base); end
    n_vec++; if (bus.data_parll !== 8'h5A) begin n_err++; $display("FAIL recover_data: got %h want 5a", bus.data_parll); end
    n_vec++; if (bus.stop_error !== 1'b0) begin n_err++; $display("FAIL recover_serr: got %b want 0", bus.stop_error); end
  endtask

  task automatic test_false_start;
    logic [15:0] b; int base;
    b = 16'hFFF0;
    base = done_cnt;
    drive(b, 4, -1, -1);
    @(negedge clk);
    n_vec++; if (bus.rx_active !== 1'b1) begin n_err++; $display("FAIL false_active: got %b want 1", bus.rx_active); end
    repeat (6 + MV) @(negedge clk);
    n_vec++; if (bus.rx_active !== 1'b0) begin n_err++; $display("FAIL false_idle: got %b want 0", bus.rx_active); end
    repeat (20) @(negedge clk);
    n_vec++; if (done_cnt - base !== 0) begin n_err++; $display("FAIL false_done: got %0d want 0", done_cnt - base); end
    n_vec++; if (bus.data_parll !== 8'h5A) begin n_err++; $display("FAIL false_data: got %h want 5a", bus.data_parll); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] b; int n, base;
    cfg(2'b00, 1'b0, 1'b1);
    build(8'hFF, 8, -1, 1, 1'b1, b, n);
    base = done_cnt;
    drive(b, LAT + 60, -1, -1);
    n_vec++; if (bus.rx_active !== 1'b1) begin n_err++; $display("FAIL mid_active: got %b want 1", bus.rx_active); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.data_parll !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h want 00", bus.data_parll); end
    n_vec++; if (bus.rx_active !== 1'b0) begin n_err++; $display("FAIL mid_rx_active: got %b want 0", bus.rx_active); end
    n_vec++; if (bus.rx_done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", bus.rx_done); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (120) @(posedge clk); #1;
    n_vec++; if (done_cnt - base !== 0) begin n_err++; $display("FAIL mid_count: got %0d want 0", done_cnt - base); end
    n_vec++; if (bus.data_parll !== 8'h00) begin n_err++; $display("FAIL mid_after: got %h want 00", bus.data_parll); end
  endtask

  task automatic test_glitch;
    logic [15:0] b; int n, base;
    logic [7:0] want;
`ifdef RX_MAJORITY_VOTE_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    cfg(2'b00, 1'b0, 1'b1);
    build(8'h00, 8, -1, 1, 1'b1, b, n);
    base = done_cnt;
    drive(b, n * OS, OS / 2 - 1 + OS * 4, -1);
    repeat (4) @(posedge clk); #1;
    n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL glitch_count: got %0d want 1", done_cnt - base); end
    n_vec++; if (bus.data_parll !== want) begin n_err++; $display("FAIL glitch_data: got %h want %h", bus.data_parll, want); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] b1, b2; int n, base, st;
    cfg(2'b00, 1'b0, 1'b1);
    build(8'h3C, 8, -1, 1, 1'b1, b1, n);
    build(8'hC3, 8, -1, 1, 1'b1, b2, n);
    base = done_cnt;
    drive(b1, n * OS, -1, -1);
    n_vec++; if (done_data !== 8'h3C) begin n_err++; $display("FAIL b2b_first: got %h want 3c", done_data); end
    st = cyc;
    drive(b2, n * OS, -1, -1);
    repeat (4) @(posedge clk); #1;
    n_vec++; if (done_cnt - base !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", done_cnt - base); end
    n_vec++; if (done_data !== 8'hC3) begin n_err++; $display("FAIL b2b_second: got %h want c3", done_data); end
    n_vec++; if (done_cyc - st !== exp_done(n)) begin n_err++; $display("FAIL b2b_time: got %0d want %0d", done_cyc - st, exp_done(n)); end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity_odd;
    test_7e2_len_change;
    test_break;
    test_false_start;
    test_reset_mid;
    test_glitch;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
